// File: rtl/answer_entry.sv
// Keypad answer collector: gathers up to MAX_DIGITS decimal digits into a binary value,
// one digit per key press, while the game FSM sits in the entry state.
module answer_entry #(
    parameter int unsigned MAX_DIGITS  = 4,
    parameter logic [3:0]  ENTRY_STATE = 4'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic [2:0]  level,
    input  logic        read,
    input  logic [3:0]  number,
    output logic [13:0] answer,
    output logic [2:0]  digit_count,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    localparam logic [2:0] MaxDigits = 3'(MAX_DIGITS);
    localparam logic [3:0] NoKey     = 4'd11;

    typedef enum logic [1:0] {
        StIdle,
        StWaitDigit,
        StWaitRelease,
        StDone
    } fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic [13:0] answer_q, answer_d;
    logic [2:0]  count_q, count_d;
    logic [2:0]  target_q, target_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;

    logic        entry_active;
    logic        key_valid;
    logic        digit_event;
    logic        key_released;
    logic [2:0]  target_sel;

    always_comb begin
        entry_active = (state == ENTRY_STATE);
        key_valid    = (number <= 4'd9);
        digit_event  = read && key_valid;
        // Invalid codes (10, 12..15) are ignored outright, so they cannot end a release either.
        key_released = (number == NoKey) || (!read && key_valid);

        if (level == 3'd0) begin
            target_sel = 3'd1;
        end else if (level > MaxDigits) begin
            target_sel = MaxDigits;
        end else begin
            target_sel = level;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        answer_d  = answer_q;
        count_d   = count_q;
        target_d  = target_q;
        aborted_d = 1'b0;

        case (fsm_q)
            StIdle: begin
                if (entry_active) begin
                    fsm_d    = StWaitDigit;
                    answer_d = '0;
                    count_d  = '0;
                    target_d = target_sel;
                end
            end
            StWaitDigit: begin
                // Leaving the entry state wins over a digit sampled on the same edge.
                if (!entry_active) begin
                    fsm_d     = StIdle;
                    answer_d  = '0;
                    count_d   = '0;
                    aborted_d = 1'b1;
                end else if (digit_event) begin
                    answer_d = answer_q * 14'd10 + {10'd0, number};
                    count_d  = count_q + 3'd1;
                    fsm_d    = (count_d == target_q) ? StDone : StWaitRelease;
                end
            end
            StWaitRelease: begin
                if (!entry_active) begin
                    fsm_d     = StIdle;
                    answer_d  = '0;
                    count_d   = '0;
                    aborted_d = 1'b1;
                end else if (key_released) begin
                    fsm_d = StWaitDigit;
                end
            end
            StDone: begin
                if (!entry_active) begin
                    fsm_d = StIdle;
                end
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase

        busy_d = (fsm_d == StWaitDigit) || (fsm_d == StWaitRelease);
        done_d = (fsm_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= StIdle;
            answer_q  <= '0;
            count_q   <= '0;
            target_q  <= 3'd1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            answer_q  <= answer_d;
            count_q   <= count_d;
            target_q  <= target_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign answer      = answer_q;
    assign digit_count = count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

endmodule
